// File: rtl/matmul_pkg.sv
// Shared types and defaults for the systolic matrix-multiplier sequencing controller.
package matmul_pkg;

   localparam int unsigned MM_DATA_WIDTH = 8;
   localparam int unsigned MM_BUS_WIDTH  = 16;
   localparam int unsigned MM_MAX_DIM    = MM_BUS_WIDTH / MM_DATA_WIDTH;
   localparam int unsigned WD_CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_DIM     = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_e;

   // Dimension fields carry size minus one.
   function automatic logic dim_ok(input logic [1:0] d, input int unsigned max_dim);
      return (32'(d) + 32'd1) <= max_dim;
   endfunction

endpackage

// File: rtl/matmul_ctrl_watchdog.sv
// RUN-cycle counter and limit comparator; only instantiated with MATMUL_CTRL_WATCHDOG_EN.
module matmul_ctrl_watchdog #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             timeout_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (!run_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Fires during the limit-th RUN cycle, so start is high exactly limit cycles.
   assign timeout_o = run_i && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencing controller for the systolic matrix multiplier.
// Optional RUN watchdog enabled by defining MATMUL_CTRL_WATCHDOG_EN.
module matmul_ctrl
   import matmul_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH    = MM_DATA_WIDTH,
   parameter  int unsigned BUS_WIDTH     = MM_BUS_WIDTH,
   parameter  int unsigned TIMEOUT_SLACK = 4,
   localparam int unsigned MAX_DIM       = BUS_WIDTH / DATA_WIDTH,
   localparam int unsigned ELEMS         = MAX_DIM * MAX_DIM
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [1:0]                    cmd_n_dim_i,
   input  logic [1:0]                    cmd_k_dim_i,
   input  logic [1:0]                    cmd_m_dim_i,
   input  logic                          cmd_acc_i,
   input  logic [ELEMS*DATA_WIDTH-1:0]   cmd_a_i,
   input  logic [ELEMS*DATA_WIDTH-1:0]   cmd_b_i,
   output logic                          mul_start_o,
   output logic                          mul_mode_bit_o,
   output logic [1:0]                    mul_n_dim_o,
   output logic [1:0]                    mul_k_dim_o,
   output logic [1:0]                    mul_m_dim_o,
   output logic [ELEMS*DATA_WIDTH-1:0]   mul_a_o,
   output logic [ELEMS*DATA_WIDTH-1:0]   mul_b_o,
   output logic [ELEMS*BUS_WIDTH-1:0]    mul_c_o,
   input  logic                          mul_finish_i,
   input  logic [ELEMS*BUS_WIDTH-1:0]    mul_c_i,
   input  logic [ELEMS-1:0]              mul_flags_i,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [ELEMS*BUS_WIDTH-1:0]    res_c_o,
   output logic [ELEMS-1:0]              res_flags_o,
   output logic [1:0]                    res_err_o,
   output logic                          busy_o
);

   state_e                        state_q, state_d;
   logic [1:0]                    n_q, k_q, m_q;
   logic                          acc_q;
   logic [ELEMS*DATA_WIDTH-1:0]   a_q, b_q;
   logic [ELEMS*BUS_WIDTH-1:0]    res_c_q;
   logic [ELEMS-1:0]              res_flags_q;
   err_e                          res_err_q;

   logic dims_ok;
   logic accept, capture, set_timeout;
   logic wd_timeout;

`ifdef MATMUL_CTRL_WATCHDOG_EN
   matmul_ctrl_watchdog #(
      .CNT_W(WD_CNT_W)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .run_i    (state_q == RUN),
      .limit_i  (WD_CNT_W'(n_q) + WD_CNT_W'(k_q) + WD_CNT_W'(m_q)
                 + WD_CNT_W'(3 + TIMEOUT_SLACK)),
      .timeout_o(wd_timeout)
   );
`else
   assign wd_timeout = 1'b0;
`endif

   assign dims_ok = dim_ok(cmd_n_dim_i, MAX_DIM) && dim_ok(cmd_k_dim_i, MAX_DIM)
                 && dim_ok(cmd_m_dim_i, MAX_DIM);

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               accept  = 1'b1;
               state_d = dims_ok ? RUN : RESP;
            end
         end
         RUN: begin
            // A finish arriving on the limit cycle still wins over the timeout.
            if (mul_finish_i) begin
               capture = 1'b1;
               state_d = RESP;
            end else if (wd_timeout) begin
               set_timeout = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q         <= '0;
         k_q         <= '0;
         m_q         <= '0;
         acc_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_c_q     <= '0;
         res_flags_q <= '0;
         res_err_q   <= ERR_OK;
      end else begin
         if (accept) begin
            n_q   <= cmd_n_dim_i;
            k_q   <= cmd_k_dim_i;
            m_q   <= cmd_m_dim_i;
            acc_q <= cmd_acc_i;
            a_q   <= cmd_a_i;
            b_q   <= cmd_b_i;
            if (!dims_ok) res_err_q <= ERR_DIM;
         end
         if (capture) begin
            res_c_q     <= mul_c_i;
            res_flags_q <= mul_flags_i;
            res_err_q   <= ERR_OK;
         end
         if (set_timeout) res_err_q <= ERR_TIMEOUT;
      end
   end

   // Decoded from the state register so reset drops start without a clock edge.
   assign cmd_ready_o    = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign mul_start_o    = (state_q == RUN);
   assign res_valid_o    = (state_q == RESP);
   assign mul_mode_bit_o = acc_q;
   assign mul_n_dim_o    = n_q;
   assign mul_k_dim_o    = k_q;
   assign mul_m_dim_o    = m_q;
   assign mul_a_o        = a_q;
   assign mul_b_o        = b_q;
   assign mul_c_o        = res_c_q;
   assign res_c_o        = res_c_q;
   assign res_flags_o    = res_flags_q;
   assign res_err_o      = res_err_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with a behavioural multiplier model.
// Covers the MATMUL_CTRL_WATCHDOG_EN build when that macro is defined.
module tb_matmul_ctrl;
   import matmul_pkg::*;

   localparam int unsigned DW = MM_DATA_WIDTH;
   localparam int unsigned BW = MM_BUS_WIDTH;
   localparam int unsigned MD = MM_MAX_DIM;
   localparam int unsigned NE = MD * MD;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              cmd_valid_i = 1'b0;
   logic              cmd_ready_o;
   logic [1:0]        cmd_n_dim_i = '0, cmd_k_dim_i = '0, cmd_m_dim_i = '0;
   logic              cmd_acc_i = 1'b0;
   logic [NE*DW-1:0]  cmd_a_i = '0, cmd_b_i = '0;
   logic              mul_start_o, mul_mode_bit_o;
   logic [1:0]        mul_n_dim_o, mul_k_dim_o, mul_m_dim_o;
   logic [NE*DW-1:0]  mul_a_o, mul_b_o;
   logic [NE*BW-1:0]  mul_c_o, mul_c_i, res_c_o;
   logic              mul_finish_i;
   logic [NE-1:0]     mul_flags_i = '0;
   logic              res_valid_o;
   logic              res_ready_i = 1'b0;
   logic [NE-1:0]     res_flags_o;
   logic [1:0]        res_err_o;
   logic              busy_o;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk_i = ~clk_i;

   matmul_ctrl #(
      .DATA_WIDTH   (DW),
      .BUS_WIDTH    (BW),
      .TIMEOUT_SLACK(4)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_n_dim_i   (cmd_n_dim_i),
      .cmd_k_dim_i   (cmd_k_dim_i),
      .cmd_m_dim_i   (cmd_m_dim_i),
      .cmd_acc_i     (cmd_acc_i),
      .cmd_a_i       (cmd_a_i),
      .cmd_b_i       (cmd_b_i),
      .mul_start_o   (mul_start_o),
      .mul_mode_bit_o(mul_mode_bit_o),
      .mul_n_dim_o   (mul_n_dim_o),
      .mul_k_dim_o   (mul_k_dim_o),
      .mul_m_dim_o   (mul_m_dim_o),
      .mul_a_o       (mul_a_o),
      .mul_b_o       (mul_b_o),
      .mul_c_o       (mul_c_o),
      .mul_finish_i  (mul_finish_i),
      .mul_c_i       (mul_c_i),
      .mul_flags_i   (mul_flags_i),
      .res_valid_o   (res_valid_o),
      .res_ready_i   (res_ready_i),
      .res_c_o       (res_c_o),
      .res_flags_o   (res_flags_o),
      .res_err_o     (res_err_o),
      .busy_o        (busy_o)
   );

   // Multiplier model: finishes after n+k+m+2 start-high cycles; C = A*B (+ C when acc).
   int  mcnt;
   logic mul_hang = 1'b0;
   logic stray_fin = 1'b0;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          mcnt <= 0;
      else if (mul_start_o) mcnt <= mcnt + 1;
      else                  mcnt <= 0;
   end

   assign mul_finish_i = stray_fin || (mul_start_o && !mul_hang &&
      mcnt == int'(mul_n_dim_o) + int'(mul_k_dim_o) + int'(mul_m_dim_o) + 1);

   function automatic logic [NE*BW-1:0] mm_model(input logic [NE*DW-1:0] a,
         input logic [NE*DW-1:0] b, input logic [NE*BW-1:0] c, input logic acc,
         input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
      logic [NE*BW-1:0] r;
      logic [BW-1:0]    s;
      r = '0;
      for (int i = 0; i < int'(MD); i++) begin
         for (int j = 0; j < int'(MD); j++) begin
            if (i <= int'(n) && j <= int'(m)) begin
               s = acc ? c[(i*MD+j)*BW +: BW] : '0;
               for (int kk = 0; kk <= int'(k) && kk < int'(MD); kk++)
                  s += BW'(a[(i*MD+kk)*DW +: DW]) * BW'(b[(kk*MD+j)*DW +: DW]);
               r[(i*MD+j)*BW +: BW] = s;
            end
         end
      end
      return r;
   endfunction

   assign mul_c_i = mm_model(mul_a_o, mul_b_o, mul_c_o, mul_mode_bit_o,
                             mul_n_dim_o, mul_k_dim_o, mul_m_dim_o);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic send_cmd(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                           input logic acc, input logic [NE*DW-1:0] a,
                           input logic [NE*DW-1:0] b);
      int w = 0;
      @(negedge clk_i);
      while (!cmd_ready_o && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 20) chk("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
      cmd_n_dim_i = n; cmd_k_dim_i = k; cmd_m_dim_i = m;
      cmd_acc_i = acc; cmd_a_i = a; cmd_b_i = b;
      cmd_valid_i = 1'b1;
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   // Returns at the first negedge with res_valid_o high; counts start-high cycles.
   task automatic wait_resp(output int starts, output logic mode);
      int it = 0;
      starts = 0;
      mode = 1'b0;
      forever begin
         @(negedge clk_i);
         if (res_valid_o) break;
         if (mul_start_o) begin
            if (starts == 0) mode = mul_mode_bit_o;
            starts++;
         end
         it++;
         if (it >= 100) begin
            chk("resp_timeout", 64'(res_valid_o), 64'd1);
            break;
         end
      end
   endtask

   task automatic handshake();
      res_ready_i = 1'b1;
      @(posedge clk_i);
      #1 res_ready_i = 1'b0;
   endtask

   typedef struct {
      logic [1:0]       n, k, m;
      logic             acc;
      logic [NE*DW-1:0] a, b;
      logic [NE-1:0]    flags_in;
      logic [1:0]       exp_err;
      logic [NE*BW-1:0] exp_c;
      logic [NE-1:0]    exp_flags;
      int               exp_starts;
   } vec_t;

   localparam logic [31:0] MA = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] MB = {8'd8, 8'd7, 8'd6, 8'd5};
   localparam logic [31:0] SA = 32'h09080703;
   localparam logic [31:0] SB = 32'h05060704;

   vec_t vecs[7];

   initial begin
      int          starts;
      logic        mode;
      int unsigned ok_valid, ok_data, ok_ready, ok_start;
      logic [63:0] hold_c;

      vecs[0] = '{2'd1, 2'd1, 2'd1, 1'b0, MA, MB, 4'h0, 2'd0,
                  {16'd50, 16'd43, 16'd22, 16'd19}, 4'h0, 5};
      vecs[1] = '{2'd1, 2'd1, 2'd1, 1'b1, MA, MB, 4'h0, 2'd0,
                  {16'd100, 16'd86, 16'd44, 16'd38}, 4'h0, 5};
      vecs[2] = '{2'd2, 2'd1, 2'd1, 1'b0, MA, MB, 4'hF, 2'd1,
                  {16'd100, 16'd86, 16'd44, 16'd38}, 4'h0, 0};
      vecs[3] = '{2'd1, 2'd1, 2'd1, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 4'b1001, 2'd0,
                  {4{16'h7E02}}, 4'b1001, 5};
      vecs[4] = '{2'd1, 2'd1, 2'd3, 1'b1, MA, MB, 4'h0, 2'd1,
                  {4{16'h7E02}}, 4'b1001, 0};
      vecs[5] = '{2'd0, 2'd0, 2'd0, 1'b0, SA, SB, 4'b0010, 2'd0,
                  64'd12, 4'b0010, 2};
      vecs[6] = '{2'd1, 2'd0, 2'd1, 1'b1, SA, SB, 4'h0, 2'd0,
                  {16'd56, 16'd32, 16'd21, 16'd24}, 4'h0, 4};

      // Reset state
      #12;
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_outs", {56'd0, busy_o, mul_start_o, res_valid_o, mul_mode_bit_o, res_err_o, 2'b00},
          64'd0);
      chk("rst_mul_c", mul_c_o, 64'd0);
      chk("rst_flags", 64'(res_flags_o), 64'd0);
      chk("rst_latches", {mul_a_o, mul_b_o}, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int v = 0; v < 7; v++) begin
         mul_flags_i = vecs[v].flags_in;
         send_cmd(vecs[v].n, vecs[v].k, vecs[v].m, vecs[v].acc, vecs[v].a, vecs[v].b);
         wait_resp(starts, mode);
         chk($sformatf("v%0d_starts", v), 64'(starts), 64'(vecs[v].exp_starts));
         chk($sformatf("v%0d_res_c", v), res_c_o, vecs[v].exp_c);
         chk($sformatf("v%0d_mul_c", v), mul_c_o, vecs[v].exp_c);
         chk($sformatf("v%0d_flags", v), 64'(res_flags_o), 64'(vecs[v].exp_flags));
         chk($sformatf("v%0d_err", v), 64'(res_err_o), 64'(vecs[v].exp_err));
         chk($sformatf("v%0d_latch", v), {mul_a_o, 26'd0, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o},
             {vecs[v].a, 26'd0, vecs[v].n, vecs[v].k, vecs[v].m});
         if (vecs[v].exp_starts > 0)
            chk($sformatf("v%0d_mode", v), 64'(mode), 64'(vecs[v].acc));
         handshake();
      end

      // Response stall: stray command and stray finish must be ignored
      mul_flags_i = 4'h0;
      send_cmd(2'd1, 2'd1, 2'd1, 1'b1, MA, MB);
      wait_resp(starts, mode);
      hold_c = {16'd106, 16'd75, 16'd43, 16'd43};
      cmd_n_dim_i = 2'd0; cmd_k_dim_i = 2'd0; cmd_m_dim_i = 2'd0;
      cmd_acc_i = 1'b0; cmd_a_i = 32'h01010101; cmd_b_i = 32'h01010101;
      cmd_valid_i = 1'b1;
      ok_valid = 0; ok_data = 0; ok_ready = 0; ok_start = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (res_valid_o && busy_o) ok_valid++;
         if (res_c_o === hold_c && res_err_o === 2'd0 && res_flags_o === 4'h0) ok_data++;
         if (!cmd_ready_o) ok_ready++;
         if (!mul_start_o) ok_start++;
         stray_fin = (c == 3);
      end
      stray_fin = 1'b0;
      chk("stall_valid", 64'(ok_valid), 64'd10);
      chk("stall_data", 64'(ok_data), 64'd10);
      chk("stall_cmd_ready", 64'(ok_ready), 64'd10);
      chk("stall_no_start", 64'(ok_start), 64'd10);
      cmd_valid_i = 1'b0;
      handshake();
      chk("post_hs_ready", {62'd0, cmd_ready_o, res_valid_o}, 64'b10);
      chk("stray_not_taken", 64'(mul_a_o), 64'(MA));

      // Multiplier never finishes
      mul_hang = 1'b1;
      send_cmd(2'd1, 2'd1, 2'd1, 1'b0, MA, MB);
`ifdef MATMUL_CTRL_WATCHDOG_EN
      wait_resp(starts, mode);
      chk("wd_starts", 64'(starts), 64'd10);
      chk("wd_err", 64'(res_err_o), 64'd2);
      chk("wd_res_c", res_c_o, hold_c);
      handshake();
      send_cmd(2'd1, 2'd1, 2'd1, 1'b0, MA, MB);
      repeat (3) @(negedge clk_i);
`else
      ok_start = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (mul_start_o && !res_valid_o) ok_start++;
      end
      chk("hang_run_held", 64'(ok_start), 64'd20);
`endif

      // Asynchronous reset mid-RUN
      chk("pre_rst_start", 64'(mul_start_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("mid_rst_start", 64'(mul_start_o), 64'd0);
      chk("mid_rst_state", {61'd0, busy_o, cmd_ready_o, res_valid_o}, 64'b010);
      chk("mid_rst_res_c", res_c_o, 64'd0);
      chk("mid_rst_mul_c", mul_c_o, 64'd0);
      chk("mid_rst_err", 64'(res_err_o), 64'd0);
      chk("mid_rst_latch", {mul_a_o, mul_b_o}, 64'd0);
      mul_hang = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencing controller for the systolic matrix-multiplier datapath. It accepts one multiply command at a time over a valid/ready handshake and validates the dimensions. It latches the operands and drives the multiplier's start/mode/dimension inputs, holding start until the multiplier reports finish. It then captures the result matrix and per-PE overflow flags into a result register, presents them on a valid/ready response port, and can feed that register back as the C operand for accumulate mode.

## Interface
- DATA_WIDTH, 8, operand element width
- BUS_WIDTH, 16, result element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
- TIMEOUT_SLACK, 4, extra cycles allowed beyond expected compute latency (used only with watchdog)

Reset polarity and synchronicity are fixed: one clock, asynchronous active-low reset.

- clk_i  in  1  clock; all logic on posedge
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i  in  2 each  dimension minus one (A is NxK, B is KxM)
- cmd_acc_i  in  1  accumulate: C = A·B + previous result
- cmd_a_i, cmd_b_i  in  MAX_DIM²·DATA_WIDTH  packed operand matrices
- mul_start_o  out  1  multiplier start
- mul_mode_bit_o  out  1  multiplier mode bit
- mul_n_dim_o, mul_k_dim_o, mul_m_dim_o  out  2 each  multiplier dimension inputs
- mul_a_o, mul_b_o  out  MAX_DIM²·DATA_WIDTH  latched operands
- mul_c_o  out  MAX_DIM²·BUS_WIDTH  result register, fed back as C
- mul_finish_i  in  1  multiplier finish
- mul_c_i  in  MAX_DIM²·BUS_WIDTH  multiplier result
- mul_flags_i  in  MAX_DIM²  per-PE overflow
- res_valid_o / res_ready_i  out/in  1  response handshake
- res_c_o  out  MAX_DIM²·BUS_WIDTH  result register
- res_flags_o  out  MAX_DIM²  captured flags
- res_err_o  out  2  0 = ok, 1 = bad dimension, 2 = timeout
- busy_o  out  1  high in any state except IDLE

## Operation
- Reset values: state IDLE; cmd_ready_o = 1; all other outputs 0, including mul_c_o, res_* and the operand and dimension latches.
- State IDLE: cmd_ready_o = 1. On cmd_valid_i, latch the command.
  - If any dimension field + 1 > MAX_DIM, go to RESP with res_err_o = 1. The result register and flags are unchanged and the multiplier is never started.
  - Otherwise go to RUN.
- State RUN: mul_start_o = 1 and mul_mode_bit_o = latched cmd_acc_i. On mul_finish_i:
  - capture mul_c_i into the result register and mul_flags_i into res_flags_o;
  - set res_err_o = 0;
  - go to RESP.
  - mul_start_o drops in that same transition, which resets the multiplier counter.
- State RESP: res_valid_o = 1. When res_ready_i is high, go to IDLE.
  - All res_* outputs stay stable while valid is high and ready is low.
- mul_c_o always equals the result register. When cmd_acc_i = 0, the multiplier ignores C.
- Overflow flags are taken from the multiplier unmodified. The controller does no arithmetic on them.

## Timing
- Command accept to mul_start_o high: 1 cycle.
- mul_start_o stays high for exactly the cycles until mul_finish_i is sampled high. For valid dimensions the multiplier finishes after n+k+m+2 start-high cycles.
- Capture edge to res_valid_o high: same edge.
- A response handshake completes on the edge where res_valid_o and res_ready_i are both high. cmd_ready_o rises on the following cycle.
- Guaranteed gap: mul_start_o is low for at least 2 cycles between operations (the RESP and IDLE cycles).
- mul_finish_i while not in RUN is ignored.
- cmd_valid_i while busy is not accepted (cmd_ready_o = 0).
- Reset mid-RUN: mul_start_o drops asynchronously, state returns to IDLE and the result register clears.

## Configuration
- MATMUL_CTRL_WATCHDOG_EN defined:
  - a RUN-cycle counter, cleared on RUN entry, is compared with n+k+m+3+TIMEOUT_SLACK;
  - on reaching the limit without finish: drop start, go to RESP with res_err_o = 2, and leave the result register and flags unchanged.
- Undefined: no counter, and RUN waits indefinitely. Error code 2 is never produced.

## Structure
- Shared package matmul_pkg holds:
  - DATA_WIDTH, BUS_WIDTH and MAX_DIM defaults;
  - the state enum (IDLE, RUN, RESP);
  - error-code constants ERR_OK, ERR_DIM and ERR_TIMEOUT.
- Sub-module matmul_ctrl_watchdog holds the counter and comparator. It is instantiated only under MATMUL_CTRL_WATCHDOG_EN.
- The controller FSM and result register stay in matmul_ctrl.

## Test plan
- Dims n=k=m=1, A = [[1,2],[3,4]], B = [[5,6],[7,8]], acc = 0 → res_c_o = [[19,22],[43,50]], flags 0, err 0, start held 5 cycles.
- Repeat the same command with acc = 1 → res_c_o = [[38,44],[86,100]].
- Dim field 2 with MAX_DIM = 2 → err 1, mul_start_o never high, res_c_o unchanged.
- Hold res_ready_i low for 10 cycles → res_valid_o and data stable, cmd_ready_o stays 0, and a second cmd_valid_i is not accepted.
- A = B = all 127, acc = 0, dims 1 → overflow flags reported in res_flags_o exactly as the multiplier raises them.
- Watchdog build with mul_finish_i tied low → err 2 after 3+3+4 = 10 RUN cycles. Also: reset asserted mid-RUN → all outputs return to reset values immediately.
